// File: rtl/max_pool_2x2_pkg.sv
// max_pool_2x2_pkg: shared sample width, zero constant and dimension check for pooling stages
package max_pool_2x2_pkg;
   localparam int DATA_WIDTH = 32;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   function automatic bit dims_ok(input int w, input int h);
      return w >= 2 && h >= 2 && w % 2 == 0 && h % 2 == 0;
   endfunction
endpackage

// File: rtl/max_pool_2x2_fp_max.sv
// fp_max: max of two floats, negatives (incl. -0) clamped to +0 before a magnitude compare
module fp_max
   import max_pool_2x2_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   logic [W-1:0] ca;
   logic [W-1:0] cb;
   assign ca = a[W-1] ? W'(FP_ZERO) : a;
   assign cb = b[W-1] ? W'(FP_ZERO) : b;
   assign y  = (ca[W-2:0] >= cb[W-2:0]) ? ca : cb;
endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming stride-2 2x2 max pooling over a raster-ordered float feature map
module max_pool_2x2
   import max_pool_2x2_pkg::FP_ZERO, max_pool_2x2_pkg::dims_ok;
#(
   parameter int DATA_WIDTH = max_pool_2x2_pkg::DATA_WIDTH,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  frame_done
);
   localparam int HW = IMG_WIDTH / 2;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int IW = HW > 1 ? $clog2(HW) : 1;

   if (!dims_ok(IMG_WIDTH, IMG_HEIGHT)) begin : g_bad_dims
      $error("max_pool_2x2: IMG_WIDTH and IMG_HEIGHT must be even and >= 2");
   end

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] line_buf [HW];
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] win_max;
   logic [IW-1:0]         idx;
   logic                  last_col;
   logic                  last_row;

   assign idx      = IW'(col >> 1);
   assign last_col = col == CW'(IMG_WIDTH - 1);
   assign last_row = row == RW'(IMG_HEIGHT - 1);

   // pair_max feeds both the line buffer (even rows) and the final window compare (odd rows)
   fp_max #(.W(DATA_WIDTH)) u_pair (
      .a(hold),
      .b(data_in),
      .y(pair_max)
   );

   fp_max #(.W(DATA_WIDTH)) u_win (
      .a(line_buf[idx]),
      .b(pair_max),
      .y(win_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         hold       <= DATA_WIDTH'(FP_ZERO);
         data_out   <= DATA_WIDTH'(FP_ZERO);
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= valid_in && row[0] && col[0];
         frame_done <= valid_in && last_col && last_row;
         if (valid_in) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
            if (!col[0]) hold <= data_in;
            if (row[0] && col[0]) data_out <= win_max;
         end
      end
   end

   // every entry is written on an even row before the odd row reads it, so no reset needed
   always_ff @(posedge clk) begin
      if (valid_in && !row[0] && col[0]) line_buf[idx] <= pair_max;
   end
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: scoreboard bench for 4x4 directed frames and back-to-back 28x28 frames
module tb_max_pool_2x2;
   typedef struct {
      logic [31:0] d;
      logic        fd;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] d4 = '0, d28 = '0;
   logic        v4 = 1'b0, v28 = 1'b0;
   logic [31:0] o4d, o28d;
   logic        o4v, o4f, o28v, o28f;

   exp_t q4[$], q28[$];
   exp_t e4, e28;
   int cyc = 0;
   int n_chk = 0, n_fail = 0, n_out28 = 0, n_fd28 = 0;

   logic [31:0] fbasic[16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000,
                               32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                               32'h00000000, 32'h00000000, 32'h00000000, 32'h40A00000};
   logic [31:0] ebasic[4] = '{32'h40800000, 32'h40800000, 32'h00000000, 32'h40A00000};
   logic [31:0] fneg[16]  = '{32'h80000000, 32'hBF800000, 32'h80000000, 32'h80000000,
                              32'h00000000, 32'h3F000000, 32'h80000000, 32'h80000000,
                              32'h3F800000, 32'h00000000, 32'h40000000, 32'h80000000,
                              32'hBF800000, 32'h3E800000, 32'hC0000000, 32'h80000000};
   logic [31:0] eneg[4]   = '{32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000};
   logic [31:0] fa[784], fb[784];

   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
      .clk(clk), .rst(rst), .data_in(d4), .valid_in(v4),
      .data_out(o4d), .valid_out(o4v), .frame_done(o4f)
   );

   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
      .clk(clk), .rst(rst), .data_in(d28), .valid_in(v28),
      .data_out(o28d), .valid_out(o28v), .frame_done(o28f)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o4v) begin
            if (q4.size() == 0) chk("dut4 unexpected valid_out", 32'd1, 32'd0);
            else begin
               e4 = q4.pop_front();
               chk("dut4 data_out", o4d, e4.d);
               chk("dut4 frame_done", {31'd0, o4f}, {31'd0, e4.fd});
               chk("dut4 output cycle", cyc, e4.due);
            end
         end else if (o4f) chk("dut4 frame_done without valid_out", 32'd1, 32'd0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (o28v) n_out28++;
         if (o28f) n_fd28++;
         if (o28v) begin
            if (q28.size() == 0) chk("dut28 unexpected valid_out", 32'd1, 32'd0);
            else begin
               e28 = q28.pop_front();
               chk("dut28 data_out", o28d, e28.d);
               chk("dut28 frame_done", {31'd0, o28f}, {31'd0, e28.fd});
               chk("dut28 output cycle", cyc, e28.due);
            end
         end else if (o28f) chk("dut28 frame_done without valid_out", 32'd1, 32'd0);
      end
   end

   task automatic px4(input logic [31:0] d);
      @(posedge clk);
      #1;
      d4 = d;
      v4 = 1'b1;
   endtask

   task automatic idle4(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         v4 = 1'b0;
      end
   endtask

   task automatic frame4(input logic [31:0] f[16], input logic [31:0] ex[4], input int gap);
      exp_t e;
      int k = 0;
      for (int i = 0; i < 16; i++) begin
         px4(f[i]);
         if ((i / 4) % 2 == 1 && i % 2 == 1) begin
            e.d = ex[k];
            e.fd = (i == 15);
            e.due = cyc + 1;
            q4.push_back(e);
            k++;
         end
         if (gap > 0) idle4(gap);
      end
      idle4(1);
   endtask

   function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic frame28(input logic [31:0] f[784]);
      exp_t e;
      for (int i = 0; i < 784; i++) begin
         @(posedge clk);
         #1;
         d28 = f[i];
         v28 = 1'b1;
         if ((i / 28) % 2 == 1 && (i % 28) % 2 == 1) begin
            e.d = umax(umax(f[i], f[i-1]), umax(f[i-28], f[i-29]));
            e.fd = (i == 783);
            e.due = cyc + 1;
            q28.push_back(e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 784; i++) begin
         fa[i] = $urandom() & 32'h7FFF_FFFF;
         fb[i] = $urandom() & 32'h7FFF_FFFF;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset valid_out", {31'd0, o4v}, 32'd0);
      chk("reset frame_done", {31'd0, o4f}, 32'd0);
      chk("reset data_out", o4d, 32'd0);
      chk("reset dut28 valid_out", {31'd0, o28v}, 32'd0);
      frame4(fbasic, ebasic, 0);
      frame4(fbasic, ebasic, 3);
      frame4(fneg, eneg, 0);
      for (int i = 0; i < 6; i++) px4(fbasic[i]);
      @(posedge clk);
      #1;
      v4 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid-frame reset data_out", o4d, 32'd0);
      chk("mid-frame reset valid_out", {31'd0, o4v}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame4(fbasic, ebasic, 0);
      frame28(fa);
      frame28(fb);
      @(posedge clk);
      #1;
      v28 = 1'b0;
      for (int t = 0; t < 10 && (q4.size() != 0 || q28.size() != 0); t++) @(posedge clk);
      @(negedge clk);
      chk("dut4 outputs missing", q4.size(), 32'd0);
      chk("dut28 outputs missing", q28.size(), 32'd0);
      chk("dut28 output count", n_out28, 32'd392);
      chk("dut28 frame_done count", n_fd28, 32'd2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
